// File: rtl/mips_imem_loader_if.sv
// Loader data path: incoming instruction-word stream plus the instruction-memory write port.
interface mips_imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_data;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips_imem_loader.sv
// Boot-time instruction-memory loader: streams words into imem, verifies an XOR checksum,
// then releases the core from reset after a fixed hold-off.
module mips_imem_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  mips_imem_loader_if.slave     bus,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RELEASE, DONE, ERROR} state_t;

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [3:0]          REL_INIT = 4'(RELEASE_CYCLES - 1);

  state_t              state;
  logic [ADDR_WIDTH:0] count_q;
  logic [31:0]         acc;
  logic [3:0]          rel_cnt;
  logic                xfer;
  logic                length_ok;
  logic [ADDR_WIDTH:0] loaded_next;

  assign xfer        = bus.in_valid && bus.in_ready;
  assign length_ok   = (word_count != '0) && (word_count <= CAPACITY);
  assign loaded_next = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // All outputs are registered; imem_we is a one-cycle pulse per accepted payload word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count_q        <= '0;
      acc            <= '0;
      rel_cnt        <= '0;
      words_loaded   <= '0;
      core_reset     <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            count_q      <= word_count;
            acc          <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            core_reset   <= 1'b1;
            if (length_ok) begin
              state        <= LOAD;
              error        <= 1'b0;
              busy         <= 1'b1;
              bus.in_ready <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= words_loaded[ADDR_WIDTH-1:0];
            bus.imem_wdata <= bus.in_data;
            acc            <= acc ^ bus.in_data;
            words_loaded   <= loaded_next;
            if (loaded_next == count_q) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          // The word after the payload is the checksum and never reaches memory.
          if (xfer) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == acc) begin
              state   <= RELEASE;
              rel_cnt <= REL_INIT;
            end else begin
              state <= ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        RELEASE: begin
          if (rel_cnt == 4'd0) begin
            state      <= DONE;
            core_reset <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
          end else begin
            rel_cnt <= rel_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_imem_loader.md
Name: mips_imem_loader

Overview:
Boot-time program loader for the pipelined MIPS core, acting as the write side of the instruction memory that the core's IF stage reads.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake.
- Writes the words sequentially into instruction memory starting at word address 0.
- Verifies an XOR checksum word that follows the payload.
- Holds the core in reset until the image is loaded and verified, then releases it.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
RELEASE_CYCLES, 4, number of cycles core_reset stays high after a good checksum before release; legal range 1..15.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin a load; sampled in IDLE, DONE or ERROR
word_count  input  ADDR_WIDTH+1  payload length in words; latched on accepted start
in_valid  input  1  in_data holds a valid word
in_ready  output  1  loader can accept a word this cycle
in_data  input  32  instruction word, or checksum word after the payload
imem_we  output  1  instruction-memory write enable, registered
imem_addr  output  ADDR_WIDTH  instruction-memory word address, registered
imem_wdata  output  32  instruction-memory write data, registered
core_reset  output  1  active-high reset to the processor
busy  output  1  high in LOAD, CHECK and RELEASE
done  output  1  level; high once the image is verified and the core is released
error  output  1  level; high after a bad length or checksum mismatch
words_loaded  output  ADDR_WIDTH+1  count of payload words accepted in the current load

Behaviour:
Reset (reset=0, takes effect immediately, including mid-operation):
- State goes to IDLE.
- core_reset=1; imem_we=0, imem_addr=0, imem_wdata=0.
- in_ready=0, busy=0, done=0, error=0, words_loaded=0, checksum accumulator=0.
- Memory contents are not cleared.

States: IDLE, LOAD, CHECK, RELEASE, DONE, ERROR. DONE and ERROR behave like IDLE, except for the status outputs they drive.

On start in IDLE/DONE/ERROR:
- Latch word_count, clear done, error, words_loaded and the accumulator; drive core_reset=1.
- If word_count==0 or word_count>2^ADDR_WIDTH, go to ERROR on the next cycle; no memory writes occur.
- Otherwise go to LOAD.

LOAD:
- in_ready=1.
- A word transfers only when in_valid && in_ready in the same cycle.
- On each transfer, the next cycle has imem_we=1, imem_addr=words_loaded (pre-increment value) and imem_wdata=in_data. Write latency is 1 cycle; imem_we is 0 in every other cycle.
- On each transfer: accumulator ^= in_data; words_loaded += 1.
- The transfer that makes words_loaded equal the latched count moves the FSM to CHECK.
- Gaps in in_valid are allowed and produce no writes.

CHECK:
- in_ready=1; the next transferred word is the checksum and is never written to memory.
- If it equals the accumulator, go to RELEASE; otherwise go to ERROR.

RELEASE:
- in_ready=0; core_reset stays 1 for exactly RELEASE_CYCLES cycles.
- Then go to DONE: core_reset=0, done=1.

ERROR:
- error=1, core_reset=1, in_ready=0.
- Held until the next start or reset.

Other rules:
- start while busy is ignored.
- The last write of a load lands before the CHECK transfer, so memory is complete before release.
- The address never wraps; the maximum legal load writes addresses 0..2^ADDR_WIDTH-1.
- The next start after DONE re-asserts core_reset in the cycle after start is sampled.

Test Plan:
1. Good load. start with word_count=3; words 0x20080064, 0x2009000A, 0x01095020, then checksum 0x0108504E.
   -> Writes at addr 0, 1, 2 with those values, each one cycle after its handshake.
   -> core_reset stays high 4 cycles after the checksum handshake, then done=1 and core_reset=0.
2. Bad checksum. Same payload, checksum 0x00000000.
   -> error=1, done=0, core_reset stays 1, no 4th write.
   -> A following start reloads correctly.
3. Throttled input. Same good load with in_valid high only every other cycle.
   -> Exactly 3 writes, correct addresses and data, no duplicates.
4. Bad length. word_count=0 -> error=1 on the next cycle, in_ready never 1, imem_we never 1. Repeat with word_count=257 -> same result.
5. Reset mid-load. Assert reset low asynchronously after 2 of 3 words.
   -> All outputs take their reset values without waiting for clk; core_reset=1.
   -> After reset deasserts, a fresh start with 3 words completes normally.
6. Full-capacity load and ignored start. word_count=256 with words equal to their index (0..255), checksum 0x00000000; pulse start during LOAD.
   -> The mid-load start is ignored.
   -> Last write is addr 0xFF, data 0x000000FF; words_loaded=256; done=1.
